// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bundle: hazard-unit redirect/stall controls, instruction memory port and IF/ID outputs.
interface fetch_pc_unit_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 16
);
  logic [1:0]         pc_src;
  logic [PC_W-1:0]    target_reg;
  logic [PC_W-1:0]    target_mem;
  logic               flush_req;
  logic [1:0]         flush_num;
  logic               bubble;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_pc;
  logic               if_id_valid;
  logic               flushing;

  modport master (
    output pc_src, target_reg, target_mem, flush_req, flush_num, bubble, imem_data,
    input  imem_addr, if_id_instr, if_id_pc, if_id_valid, flushing
  );

  modport slave (
    input  pc_src, target_reg, target_mem, flush_req, flush_num, bubble, imem_data,
    output imem_addr, if_id_instr, if_id_pc, if_id_valid, flushing
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// PC register and IF/ID register: redirect + counted NOP flush window, load-use stall holds all state.
// One-cycle latency from controls to IF/ID; imem_addr is the only combinational output (from pc_q).
module fetch_pc_unit #(
  parameter int                  PC_W      = 32,
  parameter int                  INSTR_W   = 16,
  parameter logic [PC_W-1:0]     RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst,
  fetch_pc_unit_if.slave    bus
);
  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ifpc_q, ifpc_d;
  logic               valid_q, valid_d;
  logic               flushing_q, flushing_d;

  logic [1:0]         redirect_sel;
  logic [PC_W-1:0]    redirect_pc;
  logic [1:0]         flush_len;

  // In FLUSH the latched source keeps re-sampling its target so a late RET/RTI address is tracked.
  always_comb begin
    redirect_sel = (state_q == FLUSH) ? sel_q : bus.pc_src;
    case (redirect_sel)
      2'b01:   redirect_pc = bus.target_reg;
      2'b10:   redirect_pc = bus.target_mem;
      default: redirect_pc = pc_q;
    endcase
    flush_len = (bus.flush_num == 2'd0) ? 2'd1 : bus.flush_num;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          pc_d    = redirect_pc;
          instr_d = NOP_INSTR;
          ifpc_d  = '0;
          valid_d = 1'b0;
          sel_d   = bus.pc_src;
          cnt_d   = flush_len - 2'd1;
          if (flush_len > 2'd1) state_d = FLUSH;
        end else if (!bus.bubble) begin
          pc_d    = pc_q + PC_ONE;
          instr_d = bus.imem_data;
          ifpc_d  = pc_q + PC_ONE;
          valid_d = 1'b1;
        end
      end
      FLUSH: begin
        pc_d    = redirect_pc;
        instr_d = NOP_INSTR;
        ifpc_d  = '0;
        valid_d = 1'b0;
        cnt_d   = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    flushing_d = (state_d == FLUSH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      sel_q      <= 2'b00;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      ifpc_q     <= '0;
      valid_q    <= 1'b0;
      flushing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      ifpc_q     <= ifpc_d;
      valid_q    <= valid_d;
      flushing_q <= flushing_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc    = ifpc_q;
  assign bus.if_id_valid = valid_q;
  assign bus.flushing    = flushing_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random traffic against a window-count reference model.
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_pc_unit_if #(.PC_W(32), .INSTR_W(16)) bus ();

  fetch_pc_unit #(
    .PC_W(32), .INSTR_W(16), .RESET_PC(32'h0), .NOP_INSTR(16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] pat(input logic [31:0] a);
    return a[15:0] ^ a[31:16] ^ 16'h5A3C;
  endfunction

  assign bus.imem_data = pat(bus.imem_addr);

  int errs   = 0;
  int checks = 0;

  // Reference: architectural PC, IF/ID contents, and number of squash edges still owed.
  logic [31:0] m_pc, m_ifpc;
  logic [15:0] m_instr;
  logic        m_valid;
  logic [1:0]  m_sel;
  int          m_win;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] s);
    case (s)
      2'b01:   return bus.target_reg;
      2'b10:   return bus.target_mem;
      default: return m_pc;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_instr = 16'h0000; m_valid = 1'b0;
    m_sel = 2'b00; m_win = 0;
  endtask

  task automatic model_step();
    int n;
    if (m_win > 0) begin
      m_pc = pick(m_sel);
      m_instr = 16'h0000; m_ifpc = 32'h0; m_valid = 1'b0;
      m_win--;
    end else if (bus.flush_req) begin
      n = (bus.flush_num == 2'd0) ? 1 : int'(bus.flush_num);
      m_pc = pick(bus.pc_src);
      m_instr = 16'h0000; m_ifpc = 32'h0; m_valid = 1'b0;
      m_sel = bus.pc_src;
      m_win = n - 1;
    end else if (!bus.bubble) begin
      m_instr = pat(m_pc);
      m_ifpc  = m_pc + 32'd1;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pc"},    bus.imem_addr,   m_pc);
    chk({tag, "_instr"}, bus.if_id_instr, m_instr);
    chk({tag, "_ifpc"},  bus.if_id_pc,    m_ifpc);
    chk({tag, "_valid"}, bus.if_id_valid, m_valid);
    chk({tag, "_flush"}, bus.flushing,    m_win > 0);
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_idle();
    bus.pc_src = 2'b00; bus.flush_req = 1'b0; bus.flush_num = 2'd0; bus.bubble = 1'b0;
  endtask

  task automatic flush(input logic [1:0] src, input logic [1:0] num);
    bus.flush_req = 1'b1; bus.pc_src = src; bus.flush_num = num; bus.bubble = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    bus.target_reg = 32'h0;
    bus.target_mem = 32'h0;
    model_reset();
    #2;
    check_all("reset");
    rst = 1'b0;

    // Sequential fetch from reset up to pc=5
    for (int i = 0; i < 5; i++) step("seq");
    chk("seq_pc5", bus.imem_addr, 32'd5);

    // Load-use stall for two edges
    bus.bubble = 1'b1;
    step("bub");
    step("bub");
    chk("bub_hold_pc", bus.imem_addr, 32'd5);
    chk("bub_hold_ifpc", bus.if_id_pc, 32'd5);
    bus.bubble = 1'b0;
    step("resume");
    chk("resume_pc", bus.imem_addr, 32'd6);
    step("seq");

    // JMP: single-cycle flush to register target
    bus.target_reg = 32'h40;
    flush(2'b01, 2'd1);
    step("jmp");
    chk("jmp_pc", bus.imem_addr, 32'h40);
    chk("jmp_flushing", bus.flushing, 1'b0);
    chk("jmp_valid", bus.if_id_valid, 1'b0);
    set_idle();
    step("jmp_next");
    chk("jmp_fetch", bus.if_id_instr, pat(32'h40));

    // RTI: three-cycle window tracking a late memory target; controls during the window are ignored
    bus.target_mem = 32'h11;
    flush(2'b10, 2'd3);
    step("rti0");
    chk("rti0_flushing", bus.flushing, 1'b1);
    bus.target_mem = 32'h22;
    bus.target_reg = 32'h99;
    bus.flush_req = 1'b1; bus.pc_src = 2'b01; bus.bubble = 1'b1; bus.flush_num = 2'd1;
    step("rti1");
    bus.target_mem = 32'h33;
    bus.flush_req = 1'b0; bus.bubble = 1'b1;
    step("rti2");
    chk("rti_final_pc", bus.imem_addr, 32'h33);
    chk("rti_end_flushing", bus.flushing, 1'b0);
    set_idle();
    step("rti_fetch");
    chk("rti_fetch_valid", bus.if_id_valid, 1'b1);

    // Flush and bubble together with flush_num=0: flush wins, one NOP
    bus.target_reg = 32'h10;
    flush(2'b01, 2'd0);
    bus.bubble = 1'b1;
    step("both");
    chk("both_pc", bus.imem_addr, 32'h10);
    chk("both_flushing", bus.flushing, 1'b0);
    set_idle();
    step("both_next");
    chk("both_next_pc", bus.imem_addr, 32'h11);

    // PC wrap from all-ones
    bus.target_reg = 32'hFFFF_FFFF;
    flush(2'b01, 2'd1);
    step("wrap_jmp");
    set_idle();
    step("wrap");
    chk("wrap_pc", bus.imem_addr, 32'h0);
    chk("wrap_ifpc", bus.if_id_pc, 32'h0);

    // Async reset while in FLUSH with one squash edge left
    bus.target_reg = 32'h80;
    flush(2'b01, 2'd3);
    step("rstf0");
    set_idle();
    step("rstf1");
    chk("rstf_in_flush", bus.flushing, 1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rstf_pc", bus.imem_addr, 32'h0);
    chk("rstf_flushing", bus.flushing, 1'b0);
    chk("rstf_valid", bus.if_id_valid, 1'b0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("post_rst");
    chk("post_rst_pc", bus.imem_addr, 32'd3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.target_reg = $urandom;
      bus.target_mem = $urandom;
      bus.pc_src     = 2'($urandom_range(0, 3));
      bus.flush_num  = 2'($urandom_range(0, 3));
      bus.flush_req  = ($urandom_range(0, 7) == 0);
      bus.bubble     = ($urandom_range(0, 5) == 0);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
